conv_requant: RTL and testbench
===============================

Name: conv_requant

Overview:
- Consumes the per-tile maximum absolute value and finish pulse from the conv max-tracking stage.
- Derives a power-of-two right-shift so the largest magnitude fits in OUT_W-bit signed.
- Requantizes the 16-lane signed 32-bit conv result stream to OUT_W-bit with round-half-up and saturation.
- Sits between the conv accumulator readout and the feature-map write-back buffer.

Parameters:
- LANES, 16, number of parallel conv result lanes.
- IN_W, 32, signed input lane width.
- OUT_W, 8, signed output lane width (minimum 2).
- SH_W, 6, width of the shift amount; must satisfy 2^SH_W > IN_W-OUT_W+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- max_valid  in  1  one-cycle pulse: max_abs is valid (driven by the max stage's finish flag).
- max_abs  in  IN_W  tile max magnitude; treated as unsigned.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*IN_W  signed lanes; lane i at bits [i*IN_W +: IN_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*OUT_W  signed requantized lanes, same lane packing.
- shift_out  out  SH_W  shift currently in force.
- busy  out  1  high in SCAN state.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, shift_out=0, busy=0; both pipeline stage valids cleared.
- Reset mid-operation discards in-flight beats and the current shift.
- FSM states are IDLE, SCAN, RUN.
- IDLE:
  - in_ready=0.
  - max_valid → latch max_abs into mq, set idx=IN_W-1, go to SCAN.
- SCAN (busy=1, in_ready=0), one bit per cycle:
  - If mq[idx]==1 or idx==OUT_W-2: shift_out <= idx-(OUT_W-2), go to RUN.
  - Otherwise idx <= idx-1.
  - Worst case is IN_W-OUT_W+2 cycles (26 with defaults); 1 cycle when mq[IN_W-1]=1.
  - max_abs=0 yields shift 0.
- RUN:
  - in_ready = stage-1 can advance, i.e. !s1_valid || !s2_valid || out_ready.
  - Remains in RUN indefinitely.
  - max_valid in RUN or SCAN: latch the new max_abs, restart SCAN, in_ready drops the next cycle.
  - Beats already accepted complete with the shift captured at their acceptance.
- Datapath, a 2-stage pipeline with back-pressure:
  - Stage 1 per lane: r = (sign-extended x, IN_W+1 bits) + (shift>0 ? 1<<(shift-1) : 0), arithmetic >>> shift. Registered.
  - Stage 2: saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Registered into out_data.
- Latency is 2 cycles from acceptance to out_valid when not stalled.
- Full throughput is 1 beat/cycle.
- When out_valid && !out_ready, out_data holds stable and no beat is dropped or duplicated.
- Simultaneous max_valid and in_valid handshake in the same cycle: the beat is accepted with the old shift.

Optional Feature:
- Macro REQUANT_RELU_EN.
- When defined: stage 2 clamps negative results to 0 after saturation, giving range [0, 2^(OUT_W-1)-1].
- When undefined: full signed saturation range.
- Shift derivation is unchanged either way.

Decomposition:
- Package conv_requant_pkg holds:
  - state enum {IDLE, SCAN, RUN};
  - default LANES/IN_W/OUT_W/SH_W constants;
  - a saturation-bounds function.
- One sub-module, requant_lane: per-lane round, shift and saturate registers, instantiated LANES times via generate.
- Lane stall enables are driven from the top.

Test Plan:
- Shift from 1000: max_valid with max_abs=1000 → SCAN takes 23 cycles, shift_out=3. Lane x=1000 → 125; x=-1000 → -125; x=1023 → 127 (saturated).
- Shift from 100: max_abs=100 → shift_out=0. x=100 → 100; x=-128 → -128; x=-129 → -128.
- Most-negative input: max_abs=32'h80000000 → SCAN 1 cycle, shift_out=25. x=32'h7FFFFFFF → 64 → saturates to 63? no: (2^31-1+2^24)>>25 = 64 → 64. x=-2^31 → -64.
- Back-pressure: stream 8 beats with out_ready toggling 1,0,0,1… → all 8 beats appear in order, none duplicated or lost, out_data stable while stalled.
- Re-scan mid-stream: max_valid arrives mid-stream with max_abs=255 → in-flight beats use shift 3, in_ready low during SCAN, later beats use shift 1. x=255 → 127 (round 256>>1=128 → saturates 127).
- Reset: assert rst_n low during SCAN and with 2 beats in flight → out_valid=0, state IDLE, shift_out=0. With REQUANT_RELU_EN defined, x=-1000 at shift 3 → 0.

Source files
------------

// File: rtl/conv_requant_pkg.sv
// ----------------------------------------------------------------------------
// conv_requant_pkg
// Shared definitions for the conv requantizer:
//   - state_t        : controller states (IDLE, SCAN, RUN)
//   - DEF_*          : default lane count and widths
//   - sat_bound()    : signed saturation limits for an out_w-bit result
// ----------------------------------------------------------------------------
package conv_requant_pkg;

    localparam int DEF_LANES = 16;
    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 8;
    localparam int DEF_SH_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RUN  = 2'd2
    } state_t;

    // upper=1: 2^(out_w-1)-1, upper=0: -2^(out_w-1)
    function automatic longint sat_bound(input int out_w, input bit upper);
        longint m;
        m = longint'(1) <<< (out_w - 1);
        return upper ? (m - 1) : -m;
    endfunction

endpackage

// File: rtl/conv_requant_lane.sv
// ----------------------------------------------------------------------------
// requant_lane
// One lane of the requantizer: round-half-up, arithmetic right shift
// (stage 1), then saturation to OUT_W-bit signed (stage 2).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en1        : stage-1 register load enable (pipeline advance)
//   en2        : stage-2 register load enable (pipeline advance)
//   x          : IN_W-bit signed input sample
//   shift      : right-shift amount applied in stage 1
//   y          : OUT_W-bit signed requantized result (stage-2 register)
// Build option: REQUANT_RELU_EN clamps negative results to zero after
// saturation.
// ----------------------------------------------------------------------------
module requant_lane
    import conv_requant_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en1,
    input  logic              en2,
    input  logic [IN_W-1:0]   x,
    input  logic [SH_W-1:0]   shift,
    output logic [OUT_W-1:0]  y
);

    localparam logic signed [IN_W:0] HI = (IN_W+1)'(sat_bound(OUT_W, 1'b1));
    localparam logic signed [IN_W:0] LO = (IN_W+1)'(sat_bound(OUT_W, 1'b0));

    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] r_next;
    logic signed [IN_W:0] r_reg;
    logic [OUT_W-1:0]     y_next;
    logic [OUT_W-1:0]     y_reg;

    // One extra bit of headroom so adding the rounding half never wraps.
    assign x_ext  = {x[IN_W-1], x};
    assign rnd    = (shift != '0) ? ((IN_W+1)'(1) << (shift - SH_W'(1))) : '0;
    assign sum    = x_ext + rnd;
    assign r_next = sum >>> shift;

    always_comb begin
        y_next = r_reg[OUT_W-1:0];
        if (r_reg > HI) begin
            y_next = HI[OUT_W-1:0];
        end else if (r_reg < LO) begin
            y_next = LO[OUT_W-1:0];
        end
`ifdef REQUANT_RELU_EN
        if (y_next[OUT_W-1]) begin
            y_next = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
            y_reg <= '0;
        end else begin
            if (en1) begin
                r_reg <= r_next;
            end
            if (en2) begin
                y_reg <= y_next;
            end
        end
    end

    assign y = y_reg;

endmodule

// File: rtl/conv_requant.sv
// ----------------------------------------------------------------------------
// conv_requant
// Derives a power-of-two right shift from the tile max magnitude (bit scan,
// one bit per cycle) and requantizes a LANES-wide signed IN_W stream to
// OUT_W-bit signed through a 2-stage back-pressured pipeline.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   max_valid   : pulse, max_abs valid -> (re)start the shift scan
//   max_abs     : tile max magnitude (unsigned)
//   in_valid / in_ready / in_data   : input beat handshake, lane i at
//                                     [i*IN_W +: IN_W]
//   out_valid / out_ready / out_data: output beat handshake, lane i at
//                                     [i*OUT_W +: OUT_W]
//   shift_out   : shift currently applied to newly accepted beats
//   busy        : high while scanning
// Build option: REQUANT_RELU_EN (see requant_lane) clamps outputs to >= 0.
// ----------------------------------------------------------------------------
module conv_requant
    import conv_requant_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   max_valid,
    input  logic [IN_W-1:0]        max_abs,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [SH_W-1:0]        shift_out,
    output logic                   busy
);

    localparam int IDX_W = $clog2(IN_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(IN_W - 1);
    // Lowest bit position the scan may stop at: a magnitude below
    // 2^(OUT_W-1) already fits, so the shift bottoms out at zero there.
    localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(OUT_W - 2);

    state_t            state_reg, state_next;
    logic [IN_W-1:0]   mq_reg, mq_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [SH_W-1:0]   shift_reg, shift_next;
    logic              s1_valid_reg;
    logic              s2_valid_reg;
    logic              adv1;
    logic              adv2;
    logic              accept;

    // Stage 2 can take a new value when empty or being drained; stage 1
    // when empty or stage 2 can take its contents.
    assign adv2   = !s2_valid_reg || out_ready;
    assign adv1   = !s1_valid_reg || adv2;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        mq_next    = mq_reg;
        idx_next   = idx_reg;
        shift_next = shift_reg;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
            end
            SCAN: begin
                busy = 1'b1;
                if (mq_reg[idx_reg] || (idx_reg == IDX_MIN)) begin
                    shift_next = SH_W'(idx_reg - IDX_MIN);
                    state_next = RUN;
                end else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end
            RUN: begin
                in_ready = adv1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A new tile max restarts the scan from any state; the current
        // shift stays in force until the scan completes.
        if (max_valid) begin
            mq_next    = max_abs;
            idx_next   = IDX_TOP;
            state_next = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mq_reg       <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            mq_reg    <= mq_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            if (adv1) begin
                s1_valid_reg <= accept;
            end
            if (adv2) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            requant_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W),
                .SH_W  (SH_W)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en1   (adv1),
                .en2   (adv2),
                .x     (in_data[gi*IN_W +: IN_W]),
                .shift (shift_reg),
                .y     (out_data[gi*OUT_W +: OUT_W])
            );
        end
    endgenerate

    assign out_valid = s2_valid_reg;
    assign shift_out = shift_reg;

endmodule

// File: tb/tb_conv_requant.sv
// ----------------------------------------------------------------------------
// tb_conv_requant
// Self-checking bench for conv_requant. Expected beats come from a
// arithmetic reference (floor((x + 2^s/2) / 2^s), clamp) using the shift the
// bench derives from the highest set bit of max_abs.
// Build option: REQUANT_RELU_EN must match the RTL build.
// ----------------------------------------------------------------------------
module tb_conv_requant;

    localparam int LANES = 16;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int SH_W  = 6;
`ifdef REQUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   max_valid;
    logic [IN_W-1:0]        max_abs;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [SH_W-1:0]        shift_out;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    int model_cur = 0;
    int beat_no = 0;
    logic [LANES*OUT_W-1:0] exp_q[$];
    logic [LANES*OUT_W-1:0] act_q[$];

    conv_requant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .max_valid (max_valid),
        .max_abs   (max_abs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .shift_out (shift_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int top_bit(input logic [IN_W-1:0] m);
        int h;
        h = -1;
        for (int b = 0; b < IN_W; b++) if (m[b]) h = b;
        return h;
    endfunction

    function automatic int model_shift(input logic [IN_W-1:0] m);
        int h;
        h = top_bit(m);
        return (h > OUT_W - 2) ? h - (OUT_W - 2) : 0;
    endfunction

    function automatic int model_cycles(input logic [IN_W-1:0] m);
        int h;
        h = top_bit(m);
        if (h < OUT_W - 2) h = OUT_W - 2;
        return IN_W - h;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] expect_beat(input logic [LANES*IN_W-1:0] d, input int s);
        logic [LANES*OUT_W-1:0] r;
        longint x, dv, q, hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        dv = longint'(1) << s;
        for (int i = 0; i < LANES; i++) begin
            x = longint'($signed(d[i*IN_W +: IN_W])) + dv / 2;
            q = x / dv;
            if ((x % dv != 0) && (x < 0)) q = q - 1;   // floor division
            if (q > hi) q = hi;
            if (q < lo) q = lo;
            if (RELU && q < 0) q = 0;
            r[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [LANES*IN_W-1:0] mk(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
        logic [LANES*IN_W-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*IN_W +: IN_W] = int'($urandom) >>> $urandom_range(0, 30);
        d[0 +: IN_W]      = l0;
        d[IN_W +: IN_W]   = l1;
        d[2*IN_W +: IN_W] = l2;
        return d;
    endfunction

    // Monitor: records accepted beats (with the model's shift for new beats)
    // and delivered beats; one line per delivered beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_cur = 0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(expect_beat(in_data, model_cur));
            if (out_valid && out_ready) begin
                act_q.push_back(out_data);
                $display("beat %0d out lane0=%0d lane1=%0d lane2=%0d", beat_no,
                         $signed(out_data[0 +: OUT_W]), $signed(out_data[OUT_W +: OUT_W]),
                         $signed(out_data[2*OUT_W +: OUT_W]));
                beat_no++;
            end
            if (max_valid) model_cur = model_shift(max_abs);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_scan(input logic [IN_W-1:0] v, output int cycles);
        @(posedge clk); #1;
        max_valid = 1'b1;
        max_abs   = v;
        @(posedge clk); #1;
        max_valid = 1'b0;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    // Sends n beats and runs until every accepted beat has been delivered.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic stream(input int n, input int rdy_mode,
                          input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                          input int mv_at, input logic [IN_W-1:0] mv_val,
                          output int held_bad, output int scan_rdy_bad);
        int sent;
        int cyc;
        bit acc;
        bit stalled;
        bit pat[4];
        logic [LANES*OUT_W-1:0] held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0; cyc = 0; stalled = 0; held = '0;
        held_bad = 0; scan_rdy_bad = 0;
        exp_q.delete();
        act_q.delete();
        in_data = mk(l0, l1, l2);
        while ((sent < n || act_q.size() < exp_q.size()) && cyc < 3000) begin
            in_valid  = (sent < n);
            max_valid = (cyc == mv_at);
            max_abs   = mv_val;
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[cyc % 4] : 1'($urandom);
            @(negedge clk);
            if (stalled && (!out_valid || out_data !== held)) held_bad++;
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (busy && in_ready) scan_rdy_bad++;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_data = mk(l0, l1, l2);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        max_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (shift_out !== '0) begin errors++; $display("FAIL rst_shift got %0d want 0", shift_out); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst got rdy=%b busy=%b want 0 0", in_ready, busy); end
    endtask

    task automatic test_shift_1000();
        int cyc, hb, sb;
        do_scan(32'd1000, cyc);
        checks++; if (cyc != 23) begin errors++; $display("FAIL scan_cycles_1000 got %0d want 23", cyc); end
        checks++; if (shift_out !== 6'd3) begin errors++; $display("FAIL shift_1000 got %0d want 3", shift_out); end
        stream(4, 0, 32'd1000, -32'sd1000, 32'd1023, -1, '0, hb, sb);
        checks++; if (act_q.size() != 4) begin errors++; $display("FAIL count_1000 got %0d want 4", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL beat_1000[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
        end
        if (act_q.size() > 0) begin
            checks++; if (act_q[0][0 +: 8] !== 8'd125) begin errors++; $display("FAIL lane_1000 got %0d want 125", act_q[0][0 +: 8]); end
            checks++; if (act_q[0][8 +: 8] !== (RELU ? 8'd0 : 8'h83)) begin errors++; $display("FAIL lane_m1000 got %h want %h", act_q[0][8 +: 8], RELU ? 8'd0 : 8'h83); end
            checks++; if (act_q[0][16 +: 8] !== 8'd127) begin errors++; $display("FAIL lane_1023 got %0d want 127", act_q[0][16 +: 8]); end
        end
    endtask

    task automatic test_shift_100();
        int cyc, hb, sb;
        do_scan(32'd100, cyc);
        checks++; if (cyc != 26) begin errors++; $display("FAIL scan_cycles_100 got %0d want 26", cyc); end
        checks++; if (shift_out !== 6'd0) begin errors++; $display("FAIL shift_100 got %0d want 0", shift_out); end
        stream(4, 0, 32'd100, -32'sd128, -32'sd129, -1, '0, hb, sb);
        checks++; if (act_q.size() != 4) begin errors++; $display("FAIL count_100 got %0d want 4", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL beat_100[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
        end
        if (act_q.size() > 0) begin
            checks++; if (act_q[0][0 +: 8] !== 8'd100) begin errors++; $display("FAIL lane_100 got %0d want 100", act_q[0][0 +: 8]); end
            checks++; if (act_q[0][8 +: 8] !== (RELU ? 8'd0 : 8'h80)) begin errors++; $display("FAIL lane_m128 got %h want %h", act_q[0][8 +: 8], RELU ? 8'd0 : 8'h80); end
            checks++; if (act_q[0][16 +: 8] !== (RELU ? 8'd0 : 8'h80)) begin errors++; $display("FAIL lane_m129 got %h want %h", act_q[0][16 +: 8], RELU ? 8'd0 : 8'h80); end
        end
    endtask

    task automatic test_most_negative();
        int cyc, hb, sb;
        do_scan(32'h8000_0000, cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL scan_cycles_msb got %0d want 1", cyc); end
        checks++; if (shift_out !== 6'd25) begin errors++; $display("FAIL shift_msb got %0d want 25", shift_out); end
        stream(3, 0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, -1, '0, hb, sb);
        checks++; if (act_q.size() != 3) begin errors++; $display("FAIL count_msb got %0d want 3", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL beat_msb[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
        end
        if (act_q.size() > 0) begin
            checks++; if (act_q[0][0 +: 8] !== 8'd64) begin errors++; $display("FAIL lane_maxpos got %0d want 64", act_q[0][0 +: 8]); end
            checks++; if (act_q[0][8 +: 8] !== (RELU ? 8'd0 : 8'hC0)) begin errors++; $display("FAIL lane_maxneg got %h want %h", act_q[0][8 +: 8], RELU ? 8'd0 : 8'hC0); end
        end
    endtask

    task automatic test_back_pressure();
        int hb, sb;
        stream(8, 1, $urandom, $urandom, $urandom, -1, '0, hb, sb);
        checks++; if (hb != 0) begin errors++; $display("FAIL bp_hold got %0d changes want 0", hb); end
        checks++; if (act_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_rescan();
        int cyc, hb, sb;
        do_scan(32'd1000, cyc);
        stream(10, 0, 32'd255, $urandom, $urandom, 3, 32'd255, hb, sb);
        checks++; if (sb != 0) begin errors++; $display("FAIL rescan_ready_in_scan got %0d cycles want 0", sb); end
        checks++; if (shift_out !== 6'd1) begin errors++; $display("FAIL rescan_shift got %0d want 1", shift_out); end
        checks++; if (act_q.size() != 10) begin errors++; $display("FAIL rescan_count got %0d want 10", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rescan_beat[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
        end
        if (act_q.size() == 10) begin
            checks++; if (act_q[0][0 +: 8] !== 8'd32) begin errors++; $display("FAIL rescan_old got %0d want 32", act_q[0][0 +: 8]); end
            checks++; if (act_q[9][0 +: 8] !== 8'd127) begin errors++; $display("FAIL rescan_new got %0d want 127", act_q[9][0 +: 8]); end
        end
    endtask

    task automatic test_random();
        int cyc, hb, sb;
        logic [IN_W-1:0] v;
        for (int r = 0; r < 4; r++) begin
            v = $urandom >> $urandom_range(0, 31);
            do_scan(v, cyc);
            checks++; if (cyc != model_cycles(v)) begin errors++; $display("FAIL rnd_cycles[%0d] got %0d want %0d", r, cyc, model_cycles(v)); end
            checks++; if (int'(shift_out) != model_shift(v)) begin errors++; $display("FAIL rnd_shift[%0d] got %0d want %0d", r, shift_out, model_shift(v)); end
            stream(12, 2, $urandom, $urandom, $urandom, -1, '0, hb, sb);
            checks++; if (hb != 0 || act_q.size() != 12) begin errors++; $display("FAIL rnd_flow[%0d] got hold=%0d n=%0d want 0 12", r, hb, act_q.size()); end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_beat[%0d][%0d] got %h want %h", r, i, act_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_midop();
        int cyc;
        do_scan(32'd1000, cyc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk($urandom, $urandom, $urandom);
        repeat (2) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        max_valid = 1'b1;
        max_abs   = 32'd5;
        @(posedge clk); #1;
        max_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (shift_out !== '0) begin errors++; $display("FAIL midrst_shift got %0d want 0", shift_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        act_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got rdy=%b ov=%b want 0 0", in_ready, out_valid); end
        checks++; if (act_q.size() != 0) begin errors++; $display("FAIL midrst_flushed got %0d beats want 0", act_q.size()); end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        max_valid = 1'b0;
        max_abs   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_shift_1000();
        test_shift_100();
        test_most_negative();
        test_back_pressure();
        test_rescan();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
